// File: rtl/gnn_input_loader.sv
// Stream-to-frame loader for the GNN datapath: collects 16 features and 24 weights,
// fires a one-cycle start pulse, then holds the buses until the datapath reports done.
module gnn_input_loader #(
  parameter int DATA_W   = 5,
  parameter int NUM_FEAT = 16,
  parameter int NUM_WT   = 24,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  input  logic                         s_sof,
  input  logic [DATA_W-1:0]            s_data,
  output logic                         s_ready,
  input  logic                         result_done,
  output logic [NUM_FEAT*DATA_W-1:0]   feat_bus,
  output logic [NUM_WT*DATA_W-1:0]     wt_bus,
  output logic                         in_ready,
  output logic                         busy,
  output logic                         frame_err,
  output logic                         timeout_err,
  output logic [7:0]                   frame_cnt
);

  localparam int NUM_WORDS = NUM_FEAT + NUM_WT;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam int FI_W      = $clog2(NUM_FEAT);
  localparam int WI_W      = $clog2(NUM_WT);
  localparam int TMO_W     = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] FEAT_LIM = IDX_W'(NUM_FEAT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              done_q;
  logic              accept;
  logic              done_rise;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  wt_off;

  logic [DATA_W-1:0] feat_mem [NUM_FEAT];
  logic [DATA_W-1:0] wt_mem   [NUM_WT];

  assign s_ready   = (state == S_IDLE) || (state == S_LOAD);
  assign busy      = (state == S_FIRE) || (state == S_WAIT);
  assign accept    = s_valid && s_ready;
  assign done_rise = result_done && !done_q;
  assign wt_off    = wr_idx - FEAT_LIM;

  // A start-of-frame word always lands in feature slot 0, whatever the current index.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (accept) begin
      if (s_sof) begin
        wr_en  = 1'b1;
        wr_idx = '0;
      end else if (state == S_LOAD) begin
        wr_en  = 1'b1;
        wr_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_FEAT; i++) feat_mem[i] <= '0;
      for (int unsigned i = 0; i < NUM_WT; i++)   wt_mem[i]   <= '0;
    end else if (wr_en) begin
      if (wr_idx < FEAT_LIM) feat_mem[wr_idx[FI_W-1:0]] <= s_data;
      else                   wt_mem[wt_off[WI_W-1:0]]   <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      tmo_cnt     <= '0;
      done_q      <= 1'b0;
      in_ready    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      done_q      <= result_done;
      in_ready    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (s_sof) begin
              idx   <= IDX_ONE;
              state <= S_LOAD;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (s_sof) begin
              idx       <= IDX_ONE;
              frame_err <= 1'b1;
            end else if (idx == IDX_LAST) begin
              idx      <= '0;
              state    <= S_FIRE;
              in_ready <= 1'b1;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        S_FIRE: begin
          state     <= S_WAIT;
          tmo_cnt   <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end
        S_WAIT: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (done_rise) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_FEAT; k++) begin : g_feat
    assign feat_bus[k*DATA_W +: DATA_W] = feat_mem[k];
  end

  for (genvar j = 0; j < NUM_WT; j++) begin : g_wt
    assign wt_bus[j*DATA_W +: DATA_W] = wt_mem[j];
  end

endmodule

// File: tb/tb_gnn_input_loader.sv
// Scoreboard bench for gnn_input_loader: a frame-level model predicts bus contents,
// frame counts and error pulses; a negedge monitor checks every in_ready against it.
module tb_gnn_input_loader;

  localparam int DW  = 5;
  localparam int NF  = 16;
  localparam int NW  = 24;
  localparam int TMO = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_sof = 1'b0;
  logic [DW-1:0]     s_data = '0;
  logic              s_ready;
  logic              result_done = 1'b0;
  logic [NF*DW-1:0]  feat_bus;
  logic [NW*DW-1:0]  wt_bus;
  logic              in_ready;
  logic              busy;
  logic              frame_err;
  logic              timeout_err;
  logic [7:0]        frame_cnt;

  gnn_input_loader #(.DATA_W(DW), .NUM_FEAT(NF), .NUM_WT(NW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
    .s_ready(s_ready), .result_done(result_done), .feat_bus(feat_bus), .wt_bus(wt_bus),
    .in_ready(in_ready), .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NF*DW-1:0] f;
    logic [NW*DW-1:0] w;
    logic [7:0]       c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mf [NF];
  logic [DW-1:0] mw [NW];
  int  m_idx = 0;
  bit  m_in_frame = 0;
  bit  m_busy = 0;
  int  m_cnt = 0;
  int  exp_ferr = 0, exp_terr = 0, ferr_seen = 0, terr_seen = 0;
  bit  cnt_pend = 0;
  logic [7:0] pend_cnt = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] ref_v);
    checks++;
    if (act !== ref_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, ref_v);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NF; k++) mf[k] = '0;
    for (int j = 0; j < NW; j++) mw[j] = '0;
    m_idx = 0; m_in_frame = 0; m_busy = 0; m_cnt = 0;
  endtask

  // Frame-level reference: what the loader should hold after each accepted word.
  task automatic model_accept(input logic [DW-1:0] d, input logic sof);
    exp_t e;
    if (sof) begin
      if (m_in_frame) exp_ferr++;
      mf[0] = d; m_idx = 1; m_in_frame = 1;
    end else if (!m_in_frame) begin
      exp_ferr++;
    end else begin
      if (m_idx < NF) mf[m_idx] = d;
      else            mw[m_idx-NF] = d;
      m_idx++;
      if (m_idx == NF + NW) begin
        m_in_frame = 0; m_busy = 1; m_cnt = (m_cnt + 1) % 256;
        for (int k = 0; k < NF; k++) e.f[k*DW +: DW] = mf[k];
        for (int j = 0; j < NW; j++) e.w[j*DW +: DW] = mw[j];
        e.c = 8'(m_cnt);
        q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sof, input int gap);
    repeat (gap) begin
      @(negedge clk); s_valid = 1'b0; s_sof = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1; s_sof = sof; s_data = d;
    chk("s_ready_when_loading", {127'd0, s_ready}, {127'd0, !m_busy});
    @(posedge clk);
    model_accept(d, sof);
  endtask

  task automatic after_frame();
    @(negedge clk);
    s_valid = 1'b0; s_sof = 1'b0;
    chk("in_ready_latency", {127'd0, in_ready}, 128'd1);
    chk("busy_in_fire", {127'd0, busy}, 128'd1);
  endtask

  task automatic complete();
    @(negedge clk); result_done = 1'b0;
    @(negedge clk);
    chk("busy_before_done_edge", {127'd0, busy}, 128'd1);
    result_done = 1'b1;
    @(negedge clk);
    chk("busy_after_done_edge", {127'd0, busy}, 128'd0);
    chk("s_ready_after_done", {127'd0, s_ready}, 128'd1);
    m_busy = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_pend) begin
        chk("frame_cnt", {120'd0, frame_cnt}, {120'd0, pend_cnt});
        chk("in_ready_one_cycle", {127'd0, in_ready}, 128'd0);
        cnt_pend = 0;
      end
      if (in_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_in_ready: got 1 expected no frame pending");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("feat_bus", {48'd0, feat_bus}, {48'd0, e.f});
          chk("wt_bus", {8'd0, wt_bus}, {8'd0, e.w});
          pend_cnt = e.c;
          cnt_pend = 1;
        end
      end
      if (frame_err) ferr_seen++;
      if (timeout_err) terr_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NF*DW-1:0] all_f;
    logic [NW*DW-1:0] all_w;
    int n;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_feat", {48'd0, feat_bus}, '0);
    chk("rst_wt", {8'd0, wt_bus}, '0);
    chk("rst_frame_cnt", {120'd0, frame_cnt}, '0);
    chk("rst_in_ready", {127'd0, in_ready}, '0);
    chk("rst_s_ready", {127'd0, s_ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, '0);
    chk("rst_errs", {126'd0, frame_err, timeout_err}, '0);
    rst_n = 1'b1;

    // Words 1..40 back to back.
    for (int i = 1; i <= NF + NW; i++) send(DW'(i), i == 1, 0);
    after_frame();
    chk("t1_feat0", {123'd0, feat_bus[4:0]}, 128'd1);
    chk("t1_feat15", {123'd0, feat_bus[79:75]}, 128'd16);
    chk("t1_wt0", {123'd0, wt_bus[4:0]}, 128'd17);
    chk("t1_wt23", {123'd0, wt_bus[119:115]}, 128'd8);
    @(negedge clk); result_done = 1'b1;
    @(negedge clk);
    chk("t1_exit_busy", {127'd0, busy}, '0);
    m_busy = 0;

    // Gapped -16 frame; result_done still high from the last frame must not exit.
    for (int i = 0; i < NF + NW; i++) send(5'b10000, i == 0, 1);
    after_frame();
    for (int k = 0; k < NF; k++) all_f[k*DW +: DW] = 5'b10000;
    for (int j = 0; j < NW; j++) all_w[j*DW +: DW] = 5'b10000;
    chk("t3_all_feat", {48'd0, feat_bus}, {48'd0, all_f});
    chk("t3_all_wt", {8'd0, wt_bus}, {8'd0, all_w});
    repeat (5) begin
      @(negedge clk);
      chk("t2_stale_done_holds", {127'd0, busy}, 128'd1);
    end
    complete();

    // Restart with sof at word 20.
    for (int i = 0; i < 19; i++) send(DW'($urandom), i == 0, 0);
    send(5'd7, 1'b1, 0);
    for (int i = 0; i < NF + NW - 1; i++) send(DW'($urandom), 1'b0, $urandom_range(0, 1));
    after_frame();
    chk("t4_feat0", {123'd0, feat_bus[4:0]}, 128'd7);
    complete();

    // Stray word in IDLE.
    send(5'd3, 1'b0, 0);
    @(negedge clk); s_valid = 1'b0;
    chk("t5_idle_s_ready", {127'd0, s_ready}, 128'd1);
    chk("t5_idle_busy", {127'd0, busy}, '0);
    chk("t5_feat0_kept", {123'd0, feat_bus[4:0]}, {123'd0, mf[0]});

    // Randomised frames with gaps and occasional restarts.
    for (int f = 0; f < 4; f++) begin
      send(DW'($urandom), 1'b1, $urandom_range(0, 2));
      while (!m_busy) send(DW'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 2));
      after_frame();
      repeat ($urandom_range(0, 20)) @(negedge clk);
      complete();
    end

    // Timeout: never complete.
    @(negedge clk); result_done = 1'b0;
    for (int i = 0; i < NF + NW; i++) send(DW'($urandom), i == 0, 0);
    after_frame();
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clk); n++;
    end
    chk("t6_timeout_cycles", 128'(n), 128'(TMO + 1));
    chk("t6_s_ready", {127'd0, s_ready}, 128'd1);
    chk("t6_busy", {127'd0, busy}, '0);
    exp_terr++;
    m_busy = 0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame.
    for (int i = 0; i < 10; i++) send(DW'($urandom | 1), i == 0, 0);
    @(negedge clk);
    s_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t7_feat_zero", {48'd0, feat_bus}, '0);
    chk("t7_wt_zero", {8'd0, wt_bus}, '0);
    chk("t7_cnt_zero", {120'd0, frame_cnt}, '0);
    chk("t7_s_ready", {127'd0, s_ready}, 128'd1);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("frame_err_pulses", 128'(ferr_seen), 128'(exp_ferr));
    chk("timeout_err_pulses", 128'(terr_seen), 128'(exp_terr));
    chk("frames_outstanding", 128'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnn_input_loader.md
Name: gnn_input_loader

Overview:
- Upstream feeder for the GNN datapath top.
- Receives one 5-bit signed word per cycle over a valid/ready stream and assembles a 40-word frame: 16 node features followed by 24 weights.
- Drives the feature and weight buses, then pulses the datapath's in_ready for one cycle.
- Holds all bus values stable until the datapath reports completion.

Parameters:
- DATA_W, 5, width of each feature/weight word.
- NUM_FEAT, 16, feature words per frame (4 nodes x 4 features).
- NUM_WT, 24, weight words per frame (16 layer-1 + 8 layer-2).
- TIMEOUT, 255, maximum cycles spent in WAIT before abort.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input word valid.
- s_sof  input  1  start-of-frame marker, qualified by s_valid.
- s_data  input  DATA_W  signed input word.
- s_ready  output  1  loader accepts a word this cycle.
- result_done  input  1  AND of the eight datapath output-ready flags (level).
- feat_bus  output  NUM_FEAT*DATA_W  features. Slot k = node*4+f holds x{f}_node{node} at bits [5k+4:5k].
- wt_bus  output  NUM_WT*DATA_W  weights. Slot j holds, in order: w04,w14,w24,w34, w05..w35, w06..w36, w07..w37, w48,w58,w68,w78, w49,w59,w69,w79.
- in_ready  output  1  one-cycle start pulse to the datapath.
- busy  output  1  high in FIRE and WAIT.
- frame_err  output  1  one-cycle pulse on a framing error.
- timeout_err  output  1  one-cycle pulse on WAIT timeout.
- frame_cnt  output  8  completed frames, wraps 255->0.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state=IDLE, word index=0;
  - feat_bus, wt_bus, frame_cnt, timeout counter = 0;
  - in_ready, frame_err, timeout_err = 0;
  - registered result_done copy = 0.
- Reset asserted mid-frame or mid-WAIT discards the frame immediately.
- States: IDLE, LOAD, FIRE, WAIT. All outputs are registered except s_ready and busy, which decode from state.
- Accept condition: s_valid && s_ready. s_ready=1 in IDLE and LOAD, 0 in FIRE and WAIT.
- IDLE:
  - Accepted word with s_sof=1 is written to feat slot 0; index=1; go to LOAD.
  - Accepted word with s_sof=0 is dropped and frame_err pulses.
- LOAD:
  - Accepted word with s_sof=0 is written to slot[index]. Index 0..15 maps to feat_bus; 16..39 maps to wt_bus slot index-16. Index then increments.
  - Accepted word with s_sof=1 restarts the frame: word written to feat slot 0, index=1, frame_err pulses. Slots already written keep their stale values until overwritten.
  - No valid word: hold state and index; gaps are unlimited.
- Word 39 accepted at edge N: state=FIRE after N, so in_ready is high for exactly the cycle N..N+1. State=WAIT after N+1; frame_cnt increments at the same edge. Latency from last accepted word to in_ready high is one cycle.
- WAIT:
  - A rising edge of result_done (registered copy 0, current 1) moves to IDLE on the next edge and clears the timeout counter.
  - A level-high result_done on WAIT entry (stale from the previous frame) does not exit; a fresh 0->1 edge is required.
  - The timeout counter increments each WAIT cycle. At TIMEOUT it pulses timeout_err, goes to IDLE and clears. If both happen in the same cycle, completion wins and no timeout_err is raised.
- The result_done registered copy updates every cycle in every state.
- Buses change only on accepted writes, so they are stable from FIRE through WAIT.
- Bus words are stored verbatim (no sign manipulation); the datapath interprets them as signed.

Test Plan:
- Reset then 40 back-to-back words 1..40 (sof on first) -> in_ready pulses once, one cycle after word 40; feat slot 0=1, slot 15=16; wt slot 0=17, slot 23=40 (5-bit truncated: 40 -> 8); frame_cnt=1; busy=1.
- In WAIT, hold result_done=1 from entry, then drop and raise it -> no exit until the 0->1 edge; IDLE one cycle after the edge; s_ready returns to 1.
- Frame with s_valid gaps (every other cycle) and s_data=-16 (5'b10000) -> in_ready after the 40th accepted word; all slots read 5'b10000.
- sof reasserted at word 20 with new data 7 -> frame_err pulses once; index restarts; in_ready only after 40 more words; feat slot 0=7.
- Word with s_sof=0 in IDLE -> frame_err pulse, word dropped, state stays IDLE, feat slot 0 unchanged.
- No result_done for 255 WAIT cycles -> timeout_err pulses once, IDLE, s_ready=1. Separately, rst_n low at word 10 -> all buses 0, frame_cnt 0, s_ready=1 immediately.
